// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side responder.
package mem_bus_pkg;

   localparam int unsigned CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic ERR_NONE     = 1'b0;
   localparam logic ERR_MISALIGN = 1'b1;

   // Number of byte lanes in a data word.
   function automatic int unsigned be_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/be_ram.sv
// Word-organized RAM with per-byte write enables and a registered read port.
module be_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Byte-masked write and registered read; read data holds when re_i is low.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
         if (we_i && be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable response latency.
module mem_responder
   import mem_bus_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH = 32,
   parameter int unsigned  ADDR_WIDTH = 11,
   parameter int unsigned  LATENCY    = 2,
   localparam int unsigned BE_WIDTH   = be_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam logic [CNT_WIDTH-1:0] LAT_LOAD =
      (LATENCY == 0) ? '0 : CNT_WIDTH'(LATENCY - 1);

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   we_q;
   logic [ADDR_WIDTH+1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [BE_WIDTH-1:0]    be_q;
   logic                   err_q, err_d;
   logic                   rd_q, rd_d;

   logic                   latch_en;
   logic                   access;
   logic                   acc_we;
   logic [ADDR_WIDTH+1:0]  acc_addr;
   logic [DATA_WIDTH-1:0]  acc_wdata;
   logic [BE_WIDTH-1:0]    acc_be;
   logic                   misalign;
   logic                   ram_we;
   logic                   ram_re;
   logic [DATA_WIDTH-1:0]  ram_rdata;

   // FSM next state, counter and access point; zero latency accesses straight from the request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      latch_en  = 1'b0;
      access    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               latch_en = 1'b1;
               if (LATENCY == 0) begin
                  access    = 1'b1;
                  acc_we    = req_we;
                  acc_addr  = req_addr;
                  acc_wdata = req_wdata;
                  acc_be    = req_be;
                  state_d   = ST_RESP;
               end else begin
                  cnt_d   = LAT_LOAD;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Access decode: misaligned requests never touch the array.
   always_comb begin
      misalign = |acc_addr[1:0];
      ram_we   = access && acc_we && !misalign;
      ram_re   = access && !acc_we && !misalign;
      err_d    = err_q;
      rd_d     = rd_q;
      if (access) begin
         err_d = misalign ? ERR_MISALIGN : ERR_NONE;
         rd_d  = ram_re;
      end else if (state_q == ST_RESP && rsp_ready) begin
         err_d = ERR_NONE;
         rd_d  = 1'b0;
      end
   end

   // State, counter and response flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= ERR_NONE;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end

   // Request latch, loaded only on the acceptance cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (latch_en) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   be_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .be_i    (acc_be),
      .addr_i  (acc_addr[ADDR_WIDTH+1:2]),
      .wdata_i (acc_wdata),
      .rdata_o (ram_rdata)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = err_q;
   assign rsp_rdata = rd_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: instance 0 with LATENCY=2, instance 1 with LATENCY=0.
module tb_mem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        we;
      logic [10:0] widx;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [12:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic [31:0] rsp_rdata [2];

   int          cyc = 0;
   int          n_chk = 0;
   int          n_bad = 0;
   int          pend [2];
   logic [31:0] last_rdata [2];
   logic        last_err [2];
   int          rise1_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .LATENCY(2)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .LATENCY(0)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard per instance: push expectation on acceptance, pop on response handshake.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int LAT = (g == 0) ? 2 : 0;
      exp_t        q [$];
      exp_t        e;
      exp_t        n;
      logic [31:0] mem_m [2048];
      logic        prev_v = 1'b0;
      int          rise_e = 0;

      always @(negedge clk) begin
         if (!rst) begin
            q.delete();
            pend[g] = 0;
            prev_v  = 1'b0;
         end else begin
            if (rsp_valid[g] && !prev_v) rise_e = cyc;
            prev_v = rsp_valid[g];
            if (rsp_valid[g] && rsp_ready[g]) begin
               if (q.size() == 0) begin
                  check_eq("unexpected_rsp", 64'(rsp_valid[g]), 64'(0));
               end else begin
                  e = q.pop_front();
                  pend[g] = q.size();
                  check_eq($sformatf("rdata%0d", g), 64'(rsp_rdata[g]), 64'(e.rdata));
                  check_eq($sformatf("err%0d", g), 64'(rsp_err[g]), 64'(e.err));
                  check_eq($sformatf("latency%0d", g), 64'(rise_e), 64'(e.acc + LAT));
                  if (e.we && !e.err) begin
                     for (int i = 0; i < 4; i++)
                        if (e.be[i]) mem_m[e.widx][8*i +: 8] = e.wdata[8*i +: 8];
                  end
                  last_rdata[g] = rsp_rdata[g];
                  last_err[g]   = rsp_err[g];
                  if (g == 1) rise1_q.push_back(rise_e);
               end
            end
            if (req_valid[g] && req_ready[g]) begin
               n.err   = (req_addr[g][1:0] != 2'b00);
               n.we    = req_we[g];
               n.widx  = req_addr[g][12:2];
               n.wdata = req_wdata[g];
               n.be    = req_be[g];
               n.rdata = (n.err || n.we) ? 32'h0 : mem_m[n.widx];
               n.acc   = cyc + 1;
               q.push_back(n);
               pend[g] = q.size();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int d, input logic we, input logic [12:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
      bit ok;
      ok = 1'b0;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      req_valid[d] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready[d]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("accept_timeout", 64'(ok), 64'(1));
      tick();
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pend[d] == 0 && req_ready[d] && !rsp_valid[d]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("idle_timeout", 64'(ok), 64'(1));
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      rst = 1'b0;
      req_valid = '0;
      req_we    = '0;
      rsp_ready = 2'b11;
      for (int d = 0; d < 2; d++) begin
         req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
      end
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_req_ready", 64'(req_ready), 64'(2'b11));
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_rsp_err", 64'(rsp_err), 64'(0));
      check_eq("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'(0));
      tick();
      rst = 1'b1;
      tick();

      // Known contents for word 5, then a write to it aborted by reset mid-wait.
      send(0, 1'b1, 13'h014, 32'h0BADF00D, 4'hF);
      wait_idle(0);
      send(0, 1'b1, 13'h014, 32'h12345678, 4'hF);
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_rsp_valid", 64'(rsp_valid[0]), 64'(0));
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      check_eq("post_rst_ready", 64'(req_ready[0]), 64'(1));
      check_eq("post_rst_valid", 64'(rsp_valid[0]), 64'(0));
      tick();
      send(0, 1'b0, 13'h014, 32'h0, 4'h0);
      wait_idle(0);
      check_eq("abort_word5", 64'(last_rdata[0]), 64'(32'h0BADF00D));

      // Write then read back.
      send(0, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF);
      wait_idle(0);
      check_eq("wr_rdata_zero", 64'(last_rdata[0]), 64'(0));
      send(0, 1'b0, 13'h010, 32'h0, 4'hF);
      wait_idle(0);
      check_eq("raw_deadbeef", 64'(last_rdata[0]), 64'(32'hDEADBEEF));

      // Partial byte-enable write.
      send(0, 1'b1, 13'h020, 32'h11223344, 4'hF);
      send(0, 1'b1, 13'h020, 32'hAABBCCDD, 4'b0101);
      send(0, 1'b0, 13'h020, 32'h0, 4'h0);
      wait_idle(0);
      check_eq("be_merge", 64'(last_rdata[0]), 64'(32'h11BB33DD));

      // Misaligned read and write; the array must stay unchanged.
      send(0, 1'b0, 13'h013, 32'h0, 4'hF);
      wait_idle(0);
      check_eq("mis_rd_err", 64'(last_err[0]), 64'(1));
      check_eq("mis_rd_data", 64'(last_rdata[0]), 64'(0));
      send(0, 1'b1, 13'h012, 32'h55555555, 4'hF);
      send(0, 1'b0, 13'h010, 32'h0, 4'hF);
      wait_idle(0);
      check_eq("mis_wr_kept", 64'(last_rdata[0]), 64'(32'hDEADBEEF));

      // Backpressure: response held for 5 cycles while a stray request waits.
      rsp_ready[0] = 1'b0;
      send(0, 1'b0, 13'h020, 32'h0, 4'hF);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin
            got = 1'b1;
            break;
         end
      end
      check_eq("bp_rsp_seen", 64'(got), 64'(1));
      tick();
      req_we[0] = 1'b1; req_addr[0] = 13'h020; req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
      req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_valid", 64'(rsp_valid[0]), 64'(1));
         check_eq("bp_rdata", 64'(rsp_rdata[0]), 64'(32'h11BB33DD));
         check_eq("bp_err", 64'(rsp_err[0]), 64'(0));
         check_eq("bp_ready", 64'(req_ready[0]), 64'(0));
         tick();
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      wait_idle(0);
      send(0, 1'b0, 13'h020, 32'h0, 4'hF);
      wait_idle(0);
      check_eq("bp_no_accept", 64'(last_rdata[0]), 64'(32'h11BB33DD));

      // Zero latency back-to-back on instance 1 with rsp_ready tied high.
      rise1_q.delete();
      send(1, 1'b1, 13'h000, 32'hCAFEF00D, 4'hF);
      send(1, 1'b1, 13'h004, 32'h01234567, 4'hF);
      send(1, 1'b0, 13'h000, 32'h0, 4'hF);
      send(1, 1'b1, 13'h004, 32'h89AB0000, 4'b1100);
      send(1, 1'b0, 13'h004, 32'h0, 4'hF);
      wait_idle(1);
      check_eq("b2b_last", 64'(last_rdata[1]), 64'(32'h89AB4567));
      check_eq("b2b_count", 64'(rise1_q.size()), 64'(5));
      for (int i = 0; i + 1 < rise1_q.size(); i++)
         check_eq($sformatf("b2b_gap%0d", i), 64'(rise1_q[i+1] - rise1_q[i]), 64'(2));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU data bus, paired with the core's load/store initiator on the other end of a valid/ready request/response interface. It replaces the combinational data memory with a word-organized, byte-enabled RAM that answers each accepted request after a programmable wait. This lets the core and its bench be exercised against realistic memory latency. One transaction is outstanding at a time; read data, write completion and alignment errors all return on a single response channel.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 11, word-index width; depth is 2^ADDR_WIDTH words
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15

- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH+2  byte address; [1:0] must be 0
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  misaligned request

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be. If LATENCY=0, go to RESP; otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter. At 0, perform the access and go to RESP.
  - RESP: rsp_valid=1. Outputs hold stable until rsp_ready is seen. On rsp_valid&&rsp_ready, go to IDLE.
- Access point (the transition into RESP):
  - Error check: latched addr[1:0]≠0 sets rsp_err=1 and rsp_rdata=0. No array write occurs.
  - Read: rsp_rdata = mem[addr[ADDR_WIDTH+1:2]]. req_be is ignored.
  - Write: only bytes with be=1 are updated; all other bytes are retained. rsp_rdata=0. be=0 is a legal no-op write that still gets a response.
- Request inputs are sampled only on the acceptance cycle. Changes in other cycles are ignored.
- Address wrap: none is needed, because the word index covers the full array.
- Reset (asynchronous, any state): FSM→IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 after release.
  - Array contents are not cleared.
  - An in-flight write aborted before its access point must not modify the array.

## Timing
- Acceptance cycle T: req_valid&&req_ready at a rising edge.
- rsp_valid rises at edge T+1+LATENCY.
- req_ready drops at T+1 and returns the cycle after the response handshake. Peak throughput is one transaction per LATENCY+2 cycles.
- rsp_valid, rsp_rdata, rsp_err and req_ready are registered or decoded from state only; there is no combinational path from req_* or rsp_ready to any output.
- Read-after-write to the same word in the next transaction returns the new data.
- If rsp_ready is already high when rsp_valid rises, the handshake completes in that cycle, so the response lasts one cycle.

## Structure
- Shared package mem_bus_pkg:
  - state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - ERR_NONE / ERR_MISALIGN constants
  - the byte-enable width expression
- Sub-module be_ram:
  - 2^ADDR_WIDTH × DATA_WIDTH synchronous array
  - per-byte write enables and a registered read port
  - no reset
- The top level holds the FSM, the latency counter, the request latch and the response registers.

## Test plan
- Reset: hold rst=0 mid-WAIT of a write to word 5 → rsp_valid=0, req_ready=1 after release; a later read of word 5 returns its pre-write value.
- Write then read, LATENCY=2: write 0xDEADBEEF to addr 0x010 accepted at T → rsp_valid at T+3 with rdata=0, err=0. A read of 0x010 then returns 0xDEADBEEF.
- Byte enables: word 0x020 = 0x11223344; write 0xAABBCCDD with be=4'b0101 → a read returns 0x11BB33DD.
- Misaligned: read addr 0x013 → rsp_err=1, rdata=0. A write to 0x012 → err=1 and the array is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rdata and err are stable, req_ready=0 throughout, and a new req_valid is not accepted.
- LATENCY=0 back-to-back with rsp_ready tied to 1 → responses at T+1, T+3, T+5, with data matching each request.
